// File: rtl/alu181_pkg.sv
// Shared types and constants for the nibble-serial 74181 word sequencer.
// Function codes are given in the active-high data convention.
package alu181_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } cmd_t;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_AND = 4'b1011;

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181-style ALU slice, active-high data,
// active-low ripple carry in/out.
module alu181_slice
  import alu181_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [3:0]         s,
  input  logic               cn_n,
  input  logic               m,
  output logic [SLICE_W-1:0] f,
  output logic               cn4_n,
  output logic               x,
  output logic               y
);

  logic [SLICE_W-1:0] e;
  logic [SLICE_W-1:0] d;
  logic [SLICE_W-1:0] cb;

  always_comb begin
    for (int i = 0; i < SLICE_W; i++) begin
      e[i] = ~((a[i] & b[i] & s[3]) | (a[i] & ~b[i] & s[2]));
      d[i] = ~((~b[i] & s[1]) | (b[i] & s[0]) | a[i]);
    end
  end

  // cb is the carry into each bit in the complemented-data domain,
  // where d acts as generate and e as propagate.
  always_comb begin
    cb[0] = cn_n;
    cb[1] = d[0] | (e[0] & cn_n);
    cb[2] = d[1] | (e[1] & d[0])
          | (e[1] & e[0] & cn_n);
    cb[3] = d[2] | (e[2] & d[1])
          | (e[2] & e[1] & d[0])
          | (e[2] & e[1] & e[0] & cn_n);
  end

  always_comb begin
    for (int i = 0; i < SLICE_W; i++) begin
      f[i] = e[i] ^ d[i] ^ (~cb[i] | m);
    end
  end

  assign y = ~(d[3]
             | (e[3] & d[2])
             | (e[3] & e[2] & d[1])
             | (e[3] & e[2] & e[1] & d[0]));

  assign x = ~(&e);

  assign cn4_n = ~(y & ~((&e) & cn_n));

endmodule

// File: rtl/alu181_word_sequencer.sv
// Word-wide front end that runs one 74181 slice nibble-serially,
// LSB nibble first, with valid/ready on both sides.
module alu181_word_sequencer
  import alu181_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic [3:0]             s,
  input  logic                   m,
  input  logic                   cin_n,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   f,
  output logic                   cout_n,
  output logic                   aeb
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t state;
  state_t state_n;

  logic [CW-1:0] cnt;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  cmd_t          cmd_q;
  logic          carry_n;
  logic          aeb_acc;
  logic          last;
  logic          accept;

  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_f;
  logic               sl_cn4_n;
  logic               slice_x_unused;
  logic               slice_y_unused;

  assign last   = (cnt == LAST);
  assign accept = in_valid && in_ready;
  assign sl_a   = a_q[SLICE_W*cnt +: SLICE_W];
  assign sl_b   = b_q[SLICE_W*cnt +: SLICE_W];

  alu181_slice u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .s     (cmd_q.s),
    .cn_n  (carry_n),
    .m     (cmd_q.m),
    .f     (sl_f),
    .cn4_n (sl_cn4_n),
    .x     (slice_x_unused),
    .y     (slice_y_unused)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      carry_n <= 1'b1;
      aeb_acc <= 1'b0;
      f       <= '0;
      cout_n  <= 1'b1;
      aeb     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            cmd_q   <= '{s: s, m: m};
            cnt     <= '0;
            carry_n <= cin_n;
            aeb_acc <= 1'b1;
          end
        end
        RUN: begin
          f[SLICE_W*cnt +: SLICE_W] <= sl_f;
          carry_n <= sl_cn4_n;
          aeb_acc <= aeb_acc & (&sl_f);
          cnt     <= cnt + 1'b1;
          // Flags are published only once the word is complete.
          if (last) begin
            cout_n <= sl_cn4_n;
            aeb    <= aeb_acc & (&sl_f);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu181_word_sequencer.sv
// Directed self-checking bench for alu181_word_sequencer (16-bit).
// Expected values are hand-computed 74181 results.
module tb_alu181_word_sequencer;
  import alu181_pkg::*;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   s = '0;
  logic         m = 1'b0;
  logic         cin_n = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] f;
  logic         cout_n;
  logic         aeb;

  int vectors = 0;
  int miscompares = 0;
  int lat;

  always #5 clk = ~clk;

  alu181_word_sequencer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .cin_n     (cin_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout_n    (cout_n),
    .aeb       (aeb)
  );

  // Called at a negedge with the DUT idle; returns at the negedge
  // where out_valid is first seen (or the budget expires).
  task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic [3:0] ts, input logic tm, input logic tc);
    a = ta; b = tb; s = ts; m = tm; cin_n = tc;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (f !== 16'h0000 || out_valid !== 1'b0 || cout_n !== 1'b1 || aeb !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got f=%h ov=%b cout_n=%b aeb=%b want 0000 0 1 0",
               f, out_valid, cout_n, aeb);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    run(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1);
    vectors++;
    if (lat !== N) begin
      miscompares++;
      $display("FAIL add_latency: got %0d want %0d", lat, N);
    end
    vectors++;
    if (f !== 16'h2345 || cout_n !== 1'b1 || aeb !== 1'b0) begin
      miscompares++;
      $display("FAIL add: got f=%h cout_n=%b aeb=%b want 2345 1 0", f, cout_n, aeb);
    end
    handoff();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL add_handoff: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_add_ripple();
    run(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1);
    vectors++;
    if (lat !== N || f !== 16'h0000 || cout_n !== 1'b0 || aeb !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple: got lat=%0d f=%h cout_n=%b aeb=%b want 4 0000 0 0",
               lat, f, cout_n, aeb);
    end
    handoff();
  endtask

  task automatic test_sub_cmp();
    run(16'h5000, 16'h1000, S_SUB, 1'b0, 1'b0);
    vectors++;
    if (lat !== N || f !== 16'h4000 || cout_n !== 1'b0 || aeb !== 1'b0) begin
      miscompares++;
      $display("FAIL sub: got lat=%0d f=%h cout_n=%b aeb=%b want 4 4000 0 0",
               lat, f, cout_n, aeb);
    end
    handoff();
    run(16'h3C3C, 16'h3C3C, S_SUB, 1'b0, 1'b1);
    vectors++;
    if (lat !== N || f !== 16'hFFFF || cout_n !== 1'b1 || aeb !== 1'b1) begin
      miscompares++;
      $display("FAIL compare: got lat=%0d f=%h cout_n=%b aeb=%b want 4 ffff 1 1",
               lat, f, cout_n, aeb);
    end
    handoff();
  endtask

  task automatic test_logic();
    for (int c = 0; c < 2; c++) begin
      run(16'hA5F0, 16'h0FF0, S_XOR, 1'b1, c[0]);
      vectors++;
      if (lat !== N || f !== 16'hAA00 || aeb !== 1'b0) begin
        miscompares++;
        $display("FAIL xor_cin%0d: got lat=%0d f=%h aeb=%b want 4 aa00 0",
                 c, lat, f, aeb);
      end
      handoff();
    end
    run(16'hF0F0, 16'hFF00, S_AND, 1'b1, 1'b1);
    vectors++;
    if (f !== 16'hF000 || aeb !== 1'b0) begin
      miscompares++;
      $display("FAIL and: got f=%h aeb=%b want f000 0", f, aeb);
    end
    handoff();
  endtask

  task automatic test_handshake();
    a = 16'h1234; b = 16'h1111; s = S_ADD; m = 1'b0; cin_n = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // in_valid stays high with a different command through RUN and DONE
    a = 16'hFFFF; b = 16'hFFFF; s = S_AND; m = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== N) begin
      miscompares++;
      $display("FAIL hs_latency: got %0d want %0d", lat, N);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== 16'h2345 ||
          cout_n !== 1'b1 || aeb !== 1'b0) begin
        miscompares++;
        $display("FAIL hs_hold%0d: got ov=%b ir=%b f=%h cout_n=%b aeb=%b want 1 0 2345 1 0",
                 i, out_valid, in_ready, f, cout_n, aeb);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    handoff();
    repeat (3) begin
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL hs_idle: got ov=%b ir=%b want 0 1", out_valid, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    run(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1);
    vectors++;
    if (lat !== N || f !== 16'h2345) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d f=%h want 4 2345", lat, f);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_one_cycle: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    run(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1);
    vectors++;
    if (lat !== N || f !== 16'h0000 || cout_n !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d f=%h cout_n=%b want 4 0000 0",
               lat, f, cout_n);
    end
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drop: got ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    a = 16'h1234; b = 16'h1111; s = S_ADD; m = 1'b0; cin_n = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (f[7:0] !== 8'h45 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_run_partial: got f=%h ov=%b want xx45 0", f, out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (f !== 16'h0000 || out_valid !== 1'b0 || cout_n !== 1'b1 || aeb !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_run_reset: got f=%h ov=%b cout_n=%b aeb=%b want 0000 0 1 0",
               f, out_valid, cout_n, aeb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_run_release: got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    run(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1);
    vectors++;
    if (lat !== N || f !== 16'h2345 || cout_n !== 1'b1 || aeb !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_run_fresh: got lat=%0d f=%h cout_n=%b aeb=%b want 4 2345 1 0",
               lat, f, cout_n, aeb);
    end
    handoff();
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_ripple();
    test_sub_cmp();
    test_logic();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
